// File: rtl/morse_transmitter.sv
// ASCII-to-Morse serialiser: one ready/valid character in, one line bit per time unit out.
// Optional build macro MORSE_END_MSG_EN: byte 0x04 sends the AR prosign and then halts until reset.
module morse_transmitter #(
    parameter int UNIT_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_data_morse,
    output logic       o_busy,
    output logic       o_err
);

    // state    | meaning
    // IDLE     | ready; the accept cycle also decodes the character (LOAD)
    // MARK     | key down for one dot or dash
    // ELEM_GAP | one unit of key up after every element
    // CHAR_GAP | remainder of the 3-unit character gap
    // WORD_GAP | space character, 4 units of key up
    // HALT     | end-of-message sent, wait for reset
    typedef enum logic [2:0] {IDLE, MARK, ELEM_GAP, CHAR_GAP, WORD_GAP, HALT} state_t;

    localparam int TW = CNT_W + 2;
    localparam logic [TW-1:0] T_DOT  = TW'(UNIT_CYCLES - 1);
    localparam logic [TW-1:0] T_DASH = TW'(3 * UNIT_CYCLES - 1);
    // Final gaps end one cycle early: the last gap cycle is presented while back in
    // IDLE, so a character accepted there abuts with no extra idle unit.
    localparam logic [TW-1:0] T_CG   = TW'(2 * UNIT_CYCLES - 2);
    localparam logic [TW-1:0] T_WG   = TW'(4 * UNIT_CYCLES - 2);

    state_t        state, state_nxt;
    logic [TW-1:0] tmr, tmr_load;
    logic [4:0]    pat_q;
    logic [2:0]    rem_q;
    logic          eot_q, err_q, morse_q;

    logic [7:0]    chr;
    logic          rom_ok, rom_eot;
    logic [2:0]    rom_len;
    logic [4:0]    rom_pat;
    logic          load, shift, err_nxt, mark_dash;

    // Code ROM: len elements, pattern left-aligned, 1 = dash
    always_comb begin
        chr     = i_data;
        if (i_data >= 8'h61 && i_data <= 8'h7a) chr = i_data - 8'h20;
        rom_ok  = 1'b1;
        rom_eot = 1'b0;
        rom_len = 3'd0;
        rom_pat = 5'b00000;
        case (chr)
            "A": {rom_len, rom_pat} = {3'd2, 5'b01000};
            "B": {rom_len, rom_pat} = {3'd4, 5'b10000};
            "C": {rom_len, rom_pat} = {3'd4, 5'b10100};
            "D": {rom_len, rom_pat} = {3'd3, 5'b10000};
            "E": {rom_len, rom_pat} = {3'd1, 5'b00000};
            "F": {rom_len, rom_pat} = {3'd4, 5'b00100};
            "G": {rom_len, rom_pat} = {3'd3, 5'b11000};
            "H": {rom_len, rom_pat} = {3'd4, 5'b00000};
            "I": {rom_len, rom_pat} = {3'd2, 5'b00000};
            "J": {rom_len, rom_pat} = {3'd4, 5'b01110};
            "K": {rom_len, rom_pat} = {3'd3, 5'b10100};
            "L": {rom_len, rom_pat} = {3'd4, 5'b01000};
            "M": {rom_len, rom_pat} = {3'd2, 5'b11000};
            "N": {rom_len, rom_pat} = {3'd2, 5'b10000};
            "O": {rom_len, rom_pat} = {3'd3, 5'b11100};
            "P": {rom_len, rom_pat} = {3'd4, 5'b01100};
            "Q": {rom_len, rom_pat} = {3'd4, 5'b11010};
            "R": {rom_len, rom_pat} = {3'd3, 5'b01000};
            "S": {rom_len, rom_pat} = {3'd3, 5'b00000};
            "T": {rom_len, rom_pat} = {3'd1, 5'b10000};
            "U": {rom_len, rom_pat} = {3'd3, 5'b00100};
            "V": {rom_len, rom_pat} = {3'd4, 5'b00010};
            "W": {rom_len, rom_pat} = {3'd3, 5'b01100};
            "X": {rom_len, rom_pat} = {3'd4, 5'b10010};
            "Y": {rom_len, rom_pat} = {3'd4, 5'b10110};
            "Z": {rom_len, rom_pat} = {3'd4, 5'b11000};
            "0": {rom_len, rom_pat} = {3'd5, 5'b11111};
            "1": {rom_len, rom_pat} = {3'd5, 5'b01111};
            "2": {rom_len, rom_pat} = {3'd5, 5'b00111};
            "3": {rom_len, rom_pat} = {3'd5, 5'b00011};
            "4": {rom_len, rom_pat} = {3'd5, 5'b00001};
            "5": {rom_len, rom_pat} = {3'd5, 5'b00000};
            "6": {rom_len, rom_pat} = {3'd5, 5'b10000};
            "7": {rom_len, rom_pat} = {3'd5, 5'b11000};
            "8": {rom_len, rom_pat} = {3'd5, 5'b11100};
            "9": {rom_len, rom_pat} = {3'd5, 5'b11110};
            " ": {rom_len, rom_pat} = {3'd0, 5'b00000};
`ifdef MORSE_END_MSG_EN
            8'h04: begin
                {rom_len, rom_pat} = {3'd5, 5'b01010};
                rom_eot = 1'b1;
            end
`endif
            default: rom_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        err_nxt   = 1'b0;
        mark_dash = pat_q[4];
        case (state)
            IDLE: begin
                if (i_valid) begin
                    if (rom_ok) begin
                        load = 1'b1;
                        if (rom_len == 3'd0) begin
                            state_nxt = WORD_GAP;
                        end else begin
                            state_nxt = MARK;
                            mark_dash = rom_pat[4];
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            MARK:     if (tmr == '0) state_nxt = ELEM_GAP;
            ELEM_GAP: begin
                if (tmr == '0) begin
                    if (rem_q == 3'd1) begin
                        state_nxt = CHAR_GAP;
                    end else begin
                        state_nxt = MARK;
                        shift     = 1'b1;
                        mark_dash = pat_q[3];
                    end
                end
            end
            CHAR_GAP: if (tmr == '0) state_nxt = eot_q ? HALT : IDLE;
            WORD_GAP: if (tmr == '0) state_nxt = IDLE;
            HALT:     state_nxt = HALT;
            default:  state_nxt = IDLE;
        endcase

        case (state_nxt)
            MARK:     tmr_load = mark_dash ? T_DASH : T_DOT;
            ELEM_GAP: tmr_load = T_DOT;
            CHAR_GAP: tmr_load = T_CG;
            WORD_GAP: tmr_load = T_WG;
            default:  tmr_load = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            tmr     <= '0;
            pat_q   <= '0;
            rem_q   <= '0;
            eot_q   <= 1'b0;
            err_q   <= 1'b0;
            morse_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            err_q   <= err_nxt;
            morse_q <= (state_nxt == MARK);
            if (state_nxt != state) tmr <= tmr_load;
            else if (tmr != '0)     tmr <= tmr - TW'(1);
            if (load) begin
                pat_q <= rom_pat;
                rem_q <= rom_len;
                eot_q <= rom_eot;
            end else if (shift) begin
                pat_q <= {pat_q[3:0], 1'b0};
                rem_q <= rem_q - 3'd1;
            end
        end
    end

    assign o_ready      = (state == IDLE) && !i_rst;
    assign o_busy       = (state != IDLE) && !i_rst;
    assign o_err        = err_q;
    assign o_data_morse = morse_q;

endmodule

// File: tb/tb_morse_transmitter.sv
// Directed bench for morse_transmitter: one DUT at UNIT_CYCLES=1, one at UNIT_CYCLES=4.
module tb_morse_transmitter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d1_data = 8'h00, d4_data = 8'h00;
    logic       d1_valid = 1'b0, d4_valid = 1'b0;
    logic       d1_ready, d1_morse, d1_busy, d1_err;
    logic       d4_ready, d4_morse, d4_busy, d4_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    morse_transmitter #(.UNIT_CYCLES(1), .CNT_W(16)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_data(d1_data), .i_valid(d1_valid),
        .o_ready(d1_ready), .o_data_morse(d1_morse), .o_busy(d1_busy), .o_err(d1_err)
    );

    morse_transmitter #(.UNIT_CYCLES(4), .CNT_W(16)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_data(d4_data), .i_valid(d4_valid),
        .o_ready(d4_ready), .o_data_morse(d4_morse), .o_busy(d4_busy), .o_err(d4_err)
    );

    // Waits for ready, hands over one character, records n line/ready samples (first sample in MSB)
    task automatic send_capture(input bit sel4, input logic [7:0] ch, input int n,
                                output logic [63:0] bits, output logic [63:0] rdys);
        int t;
        bits = '0;
        rdys = '0;
        t    = 0;
        @(negedge clk);
        while (!(sel4 ? d4_ready : d1_ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_assert++;
        if (t >= 200) begin
            n_fail++;
            $display("FAIL send_wait: o_ready stayed 0, required 1 within 200 cycles");
            return;
        end
        if (sel4) begin d4_data = ch; d4_valid = 1'b1; end
        else      begin d1_data = ch; d1_valid = 1'b1; end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin d1_valid = 1'b0; d4_valid = 1'b0; end
            bits = {bits[62:0], sel4 ? d4_morse : d1_morse};
            rdys = {rdys[62:0], sel4 ? d4_ready : d1_ready};
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_assert++; if (d1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b, required 0", d1_ready); end
        n_assert++; if (d1_busy  !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", d1_busy); end
        n_assert++; if (d1_err   !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, required 0", d1_err); end
        n_assert++; if (d1_morse !== 1'b0) begin n_fail++; $display("FAIL rst_morse: got %b, required 0", d1_morse); end
        rst = 1'b0;
        @(negedge clk);
        n_assert++; if (d1_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b, required 1", d1_ready); end
        n_assert++; if (d4_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready4: got %b, required 1", d4_ready); end
        n_assert++; if (d1_busy  !== 1'b0) begin n_fail++; $display("FAIL rst_release_busy: got %b, required 0", d1_busy); end
    endtask

    task automatic test_single_e();
        logic [63:0] b, r;
        send_capture(1'b0, "E", 4, b, r);
        n_assert++; if (b !== 64'b1000) begin n_fail++; $display("FAIL e_line: got %b, required 1000", b[3:0]); end
        n_assert++; if (r !== 64'b0001) begin n_fail++; $display("FAIL e_ready: got %b, required 0001", r[3:0]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  chars [3];
        logic [15:0] bits;
        int          idx, nb;
        bit          acc, started;
        chars   = '{"S", " ", "e"};
        bits    = '0;
        idx     = 0;
        nb      = 0;
        started = 1'b0;
        @(negedge clk);
        d1_data  = chars[0];
        d1_valid = 1'b1;
        acc      = d1_ready;
        for (int cyc = 0; cyc < 60 && nb < 16; cyc++) begin
            @(negedge clk);
            if (acc) begin
                started = 1'b1;
                idx++;
                if (idx < 3) d1_data = chars[idx];
                else         d1_valid = 1'b0;
            end
            if (started) begin
                bits = {bits[14:0], d1_morse};
                nb++;
            end
            acc = d1_valid && d1_ready;
        end
        d1_valid = 1'b0;
        n_assert++; if (nb !== 16) begin n_fail++; $display("FAIL b2b_count: got %0d units, required 16", nb); end
        n_assert++; if (bits !== 16'b1010100000001000) begin n_fail++; $display("FAIL b2b_line: got %b, required 1010100000001000", bits); end
        n_assert++; if (idx !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d, required 3", idx); end
        n_assert++; if (d1_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_end: got %b, required 1", d1_ready); end
    endtask

    task automatic test_zero();
        logic [63:0] b, r;
        send_capture(1'b0, "0", 22, b, r);
        n_assert++; if (b !== 64'b1110111011101110111000) begin n_fail++; $display("FAIL zero_line: got %b, required 1110111011101110111000", b[21:0]); end
        n_assert++; if (r !== 64'd1) begin n_fail++; $display("FAIL zero_ready: got %b, required only last sample high", r[21:0]); end
    endtask

    task automatic test_unit4();
        logic [63:0] b, r;
        send_capture(1'b1, "A", 32, b, r);
        n_assert++; if (b !== 64'hF0FFF000) begin n_fail++; $display("FAIL u4_line: got %h, required f0fff000", b[31:0]); end
        n_assert++; if (r !== 64'd1) begin n_fail++; $display("FAIL u4_ready: got %h, required 00000001", r[31:0]); end
    endtask

    task automatic test_unsupported(input logic [7:0] ch);
        @(negedge clk);
        d1_data  = ch;
        d1_valid = 1'b1;
        @(negedge clk);
        d1_valid = 1'b0;
        n_assert++; if (d1_err   !== 1'b1) begin n_fail++; $display("FAIL bad_err: char %h got %b, required 1", ch, d1_err); end
        n_assert++; if (d1_ready !== 1'b1) begin n_fail++; $display("FAIL bad_ready: char %h got %b, required 1", ch, d1_ready); end
        n_assert++; if (d1_morse !== 1'b0) begin n_fail++; $display("FAIL bad_morse: char %h got %b, required 0", ch, d1_morse); end
        @(negedge clk);
        n_assert++; if (d1_err   !== 1'b0) begin n_fail++; $display("FAIL bad_err_pulse: char %h got %b, required 0", ch, d1_err); end
        n_assert++; if (d1_morse !== 1'b0) begin n_fail++; $display("FAIL bad_morse2: char %h got %b, required 0", ch, d1_morse); end
    endtask

    task automatic test_reset_mid_char();
        logic [63:0] b, r;
        @(negedge clk);
        d1_data  = "T";
        d1_valid = 1'b1;
        @(negedge clk);
        d1_valid = 1'b0;
        n_assert++; if (d1_morse !== 1'b1) begin n_fail++; $display("FAIL t_dash: got %b, required 1", d1_morse); end
        #2 rst = 1'b1;
        #1;
        n_assert++; if (d1_morse !== 1'b0) begin n_fail++; $display("FAIL async_rst_morse: got %b, required 0", d1_morse); end
        n_assert++; if (d1_ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready: got %b, required 0", d1_ready); end
        n_assert++; if (d1_busy  !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy: got %b, required 0", d1_busy); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_assert++; if (d1_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b, required 1", d1_ready); end
        send_capture(1'b0, "E", 4, b, r);
        n_assert++; if (b !== 64'b1000) begin n_fail++; $display("FAIL post_rst_e: got %b, required 1000", b[3:0]); end
    endtask

    task automatic test_eot();
`ifdef MORSE_END_MSG_EN
        logic [63:0] b, r;
        int          hi;
        send_capture(1'b0, 8'h04, 14, b, r);
        n_assert++; if (b !== 64'b10111010111000) begin n_fail++; $display("FAIL eot_line: got %b, required 10111010111000", b[13:0]); end
        n_assert++; if (r !== 64'd0) begin n_fail++; $display("FAIL eot_ready: got %b, required all 0", r[13:0]); end
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (d1_ready || d1_morse) hi++;
        end
        n_assert++; if (hi !== 0) begin n_fail++; $display("FAIL eot_halt: got %0d cycles ready/line high, required 0", hi); end
`else
        test_unsupported(8'h04);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_e();
        test_back_to_back();
        test_zero();
        test_unit4();
        test_unsupported("#");
        test_reset_mid_char();
        test_eot();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
